// File: rtl/limbus_sysid_check.sv
// Avalon-MM reader for the limbus system-ID slave: fetches ID and build timestamp
// after reset and on each recheck, and reports whether they match this build.
module limbus_sysid_check #(
    parameter logic [31:0] EXP_ID        = 32'd0,
    parameter logic [31:0] EXP_TIMESTAMP = 32'd1415787354,
    parameter int unsigned TIMEOUT_CYC   = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        recheck,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic        av_readdatavalid,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_val,
    output logic [31:0] ts_val
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] cnt;

    logic in_req;
    logic in_wait;
    logic in_ts;
    logic accept;
    logic capture;
    logic expired;

    // Bus-facing outputs decode straight from the state register, so reset
    // drops av_read asynchronously and no input reaches an output combinationally.
    assign in_req     = (state == S_ID_REQ)  || (state == S_TS_REQ);
    assign in_wait    = (state == S_ID_WAIT) || (state == S_TS_WAIT);
    assign in_ts      = (state == S_TS_REQ)  || (state == S_TS_WAIT);
    assign av_read    = in_req;
    assign av_address = in_ts;
    assign busy       = (state != S_DONE);

    // Data in a REQ state only counts when it arrives with the accept.
    assign accept  = in_req && !av_waitrequest;
    assign capture = av_readdatavalid && (in_wait || accept);
    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_val      <= '0;
            ts_val      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_ID_REQ;
                    cnt   <= '0;
                end
                S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
                    if (capture) begin
                        if (in_ts) begin
                            ts_val <= av_readdata;
                            ts_ok  <= (av_readdata == EXP_TIMESTAMP);
                            state  <= S_DONE;
                        end else begin
                            id_val <= av_readdata;
                            id_ok  <= (av_readdata == EXP_ID);
                            state  <= S_TS_REQ;
                            cnt    <= '0;
                        end
                    end else if (expired) begin
                        // Abort: the unfinished word's match flag stays clear.
                        timeout_err <= 1'b1;
                        pass        <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (accept)
                            state <= in_ts ? S_TS_WAIT : S_ID_WAIT;
                    end
                end
                S_DONE: begin
                    if (recheck) begin
                        state       <= S_ID_REQ;
                        cnt         <= '0;
                        pass        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                    end else begin
                        done <= 1'b1;
                        pass <= id_ok & ts_ok & ~timeout_err;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_limbus_sysid_check.sv
// Bench for limbus_sysid_check: table vectors, hand-written corner sequences and
// randomized checks against a slave model and an outcome/latency reference.
module tb_limbus_sysid_check;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1415787354;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, recheck;
    logic        av_address, av_read, av_waitrequest, av_readdatavalid;
    logic [31:0] av_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout_err;
    logic [31:0] id_val, ts_val;

    logic        t_reset_n, t_recheck, t_address, t_read;
    logic        t_wreq, t_rdv;
    logic [31:0] t_rdata;
    logic        t_busy, t_done, t_pass, t_id_ok, t_ts_ok, t_timeout_err;
    logic [31:0] t_id_val, t_ts_val;

    limbus_sysid_check dut (
        .clock(clk), .reset_n(reset_n), .recheck(recheck),
        .av_address(av_address), .av_read(av_read), .av_waitrequest(av_waitrequest),
        .av_readdatavalid(av_readdatavalid), .av_readdata(av_readdata),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout_err(timeout_err), .id_val(id_val), .ts_val(ts_val)
    );

    limbus_sysid_check #(.TIMEOUT_CYC(8)) tdut (
        .clock(clk), .reset_n(t_reset_n), .recheck(t_recheck),
        .av_address(t_address), .av_read(t_read), .av_waitrequest(t_wreq),
        .av_readdatavalid(t_rdv), .av_readdata(t_rdata),
        .busy(t_busy), .done(t_done), .pass(t_pass), .id_ok(t_id_ok), .ts_ok(t_ts_ok),
        .timeout_err(t_timeout_err), .id_val(t_id_val), .ts_val(t_ts_val)
    );

    assign t_wreq  = 1'b1;
    assign t_rdv   = 1'b0;
    assign t_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: configurable stall per request and response latency after accept.
    int          s_stall_cfg, s_lat_cfg, s_stall_left, s_resp_cnt;
    logic [31:0] s_id_word, s_ts_word, s_resp_data;
    logic        s_prev_stall, s_prev_addr;
    bit          s_inject;
    int          rd_addr[$];

    task automatic slave_cfg(input logic [31:0] idw, input logic [31:0] tsw,
                             input int stall, input int lat);
        s_id_word    = idw;
        s_ts_word    = tsw;
        s_stall_cfg  = stall;
        s_lat_cfg    = lat;
        s_stall_left = stall;
        s_resp_cnt   = 0;
        s_prev_stall = 1'b0;
        rd_addr.delete();
    endtask

    always @(negedge clk) begin
        logic [31:0] word;
        av_waitrequest   = 1'b0;
        av_readdatavalid = 1'b0;
        av_readdata      = 32'hDEAD_BEEF;
        if (s_prev_stall) begin
            chk("stall_read_held", 32'(av_read), 32'd1);
            chk("stall_addr_held", 32'(av_address), 32'(s_prev_addr));
        end
        s_prev_stall = 1'b0;
        if (s_resp_cnt > 0) begin
            s_resp_cnt--;
            if (s_resp_cnt == 0) begin
                av_readdatavalid = 1'b1;
                av_readdata      = s_resp_data;
            end
        end
        if (s_inject) begin
            av_readdatavalid = 1'b1;
            av_readdata      = 32'h0BAD_0BAD;
        end
        if (reset_n && av_read) begin
            if (s_stall_left > 0) begin
                av_waitrequest = 1'b1;
                s_stall_left--;
                s_prev_stall = 1'b1;
                s_prev_addr  = av_address;
            end else begin
                rd_addr.push_back(int'(av_address));
                s_stall_left = s_stall_cfg;
                word = av_address ? s_ts_word : s_id_word;
                if (s_lat_cfg == 0) begin
                    av_readdatavalid = 1'b1;
                    av_readdata      = word;
                end else begin
                    s_resp_cnt  = s_lat_cfg;
                    s_resp_data = word;
                end
            end
        end
    end

    // Pulse recheck, then count cycles with busy high (bounded).
    task automatic run_check(output int cyc);
        @(negedge clk) recheck = 1'b1;
        @(negedge clk) recheck = 1'b0;
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 1000) chk("check_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reads(input string name);
        chk({name, "_reads"}, 32'(rd_addr.size()), 32'd2);
        if (rd_addr.size() == 2) begin
            chk({name, "_addr0"}, 32'(rd_addr[0]), 32'd0);
            chk({name, "_addr1"}, 32'(rd_addr[1]), 32'd1);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          stall;
        int          lat;
        logic        exp_pass;
        logic        exp_id_ok;
        logic        exp_ts_ok;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc, n;
        logic [31:0] idw, tsw, sv_id, sv_ts;
        int st, lt;
        logic ep;

        tbl[0] = '{"nominal",     EXP_ID,     EXP_TS,        0, 0, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{"ts_mismatch", EXP_ID,     32'h12345678,  0, 0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{"wait_states", EXP_ID,     EXP_TS,        5, 2, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{"latency1",    EXP_ID,     EXP_TS,        0, 1, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{"id_five",     32'd5,      EXP_TS,        0, 0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{"both_bad",    32'hCAFE,   32'h0,         1, 3, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; t_reset_n = 1'b0; recheck = 1'b0; t_recheck = 1'b0;
        s_inject = 1'b0;
        slave_cfg(EXP_ID, EXP_TS, 0, 0);
        repeat (3) @(negedge clk);

        chk("rst_av_read", 32'(av_read), 0);
        chk("rst_av_address", 32'(av_address), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_id_ok", 32'(id_ok), 0);
        chk("rst_ts_ok", 32'(ts_ok), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_id_val", id_val, 0);
        chk("rst_ts_val", ts_val, 0);
        chk("t_rst_av_read", 32'(t_read), 0);
        chk("t_rst_done", 32'(t_done), 0);

        // Nominal boot from reset release.
        reset_n = 1'b1;
        cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("boot_cycles", 32'(cyc), 32'd4);
        chk("boot_pass", 32'(pass), 1);
        chk("boot_id_ok", 32'(id_ok), 1);
        chk("boot_ts_ok", 32'(ts_ok), 1);
        chk("boot_id_val", id_val, EXP_ID);
        chk("boot_ts_val", ts_val, EXP_TS);
        chk_reads("boot");

        foreach (tbl[i]) begin
            slave_cfg(tbl[i].id_word, tbl[i].ts_word, tbl[i].stall, tbl[i].lat);
            run_check(cyc);
            chk({tbl[i].name, "_cycles"}, 32'(cyc), 32'(2 * (tbl[i].stall + 1 + tbl[i].lat)));
            chk({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].exp_pass));
            chk({tbl[i].name, "_id_ok"}, 32'(id_ok), 32'(tbl[i].exp_id_ok));
            chk({tbl[i].name, "_ts_ok"}, 32'(ts_ok), 32'(tbl[i].exp_ts_ok));
            chk({tbl[i].name, "_timeout"}, 32'(timeout_err), 0);
            chk({tbl[i].name, "_done"}, 32'(done), 1);
            chk({tbl[i].name, "_id_val"}, id_val, tbl[i].id_word);
            chk({tbl[i].name, "_ts_val"}, ts_val, tbl[i].ts_word);
            chk_reads(tbl[i].name);
        end

        // Stale responses in DONE are ignored.
        sv_id = id_val; sv_ts = ts_val;
        @(negedge clk) s_inject = 1'b1;
        repeat (3) @(negedge clk);
        s_inject = 1'b0;
        @(negedge clk);
        chk("stale_id_val", id_val, sv_id);
        chk("stale_ts_val", ts_val, sv_ts);
        chk("stale_busy", 32'(busy), 0);

        // recheck from a passing DONE: busy rises and pass clears together.
        slave_cfg(EXP_ID, EXP_TS, 0, 0);
        run_check(cyc);
        chk("pre_rc_pass", 32'(pass), 1);
        slave_cfg(EXP_ID, EXP_TS, 2, 1);
        @(negedge clk) recheck = 1'b1;
        @(negedge clk) recheck = 1'b0;
        chk("rc_busy_rise", 32'(busy), 1);
        chk("rc_pass_clear", 32'(pass), 0);
        chk("rc_done_kept", 32'(done), 1);
        // A recheck while busy must not queue a second check.
        @(negedge clk) recheck = 1'b1;
        @(negedge clk) recheck = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("busy_rc_idle", 32'(busy), 0);
        chk("busy_rc_pass", 32'(pass), 1);
        chk_reads("busy_rc");

        // Reset asserted while waiting for the timestamp response.
        slave_cfg(EXP_ID, EXP_TS, 0, 3);
        @(negedge clk) recheck = 1'b1;
        @(negedge clk) recheck = 1'b0;
        n = 0;
        while (!(av_address && !av_read && busy) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("mid_reach_ts_wait", 32'(n < 50), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_av_read", 32'(av_read), 0);
        chk("mid_av_address", 32'(av_address), 0);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_done", 32'(done), 0);
        chk("mid_id_ok", 32'(id_ok), 0);
        chk("mid_id_val", id_val, 0);
        chk("mid_ts_val", ts_val, 0);
        @(negedge clk);
        slave_cfg(EXP_ID, EXP_TS, 0, 0);
        @(negedge clk) reset_n = 1'b1;
        cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_rerun_cycles", 32'(cyc), 32'd4);
        chk("mid_rerun_pass", 32'(pass), 1);
        chk_reads("mid_rerun");

        // Randomized checks against the outcome/latency reference.
        for (int k = 0; k < 25; k++) begin
            idw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            tsw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            st  = int'($urandom_range(0, 4));
            lt  = int'($urandom_range(0, 3));
            ep  = (idw == EXP_ID) && (tsw == EXP_TS);
            slave_cfg(idw, tsw, st, lt);
            run_check(cyc);
            chk("rnd_cycles", 32'(cyc), 32'(2 * (st + 1 + lt)));
            chk("rnd_pass", 32'(pass), 32'(ep));
            chk("rnd_id_ok", 32'(id_ok), 32'(idw == EXP_ID));
            chk("rnd_ts_ok", 32'(ts_ok), 32'(tsw == EXP_TS));
            chk("rnd_id_val", id_val, idw);
            chk("rnd_ts_val", ts_val, tsw);
            chk("rnd_reads", 32'(rd_addr.size()), 32'd2);
        end

        // Timeout instance: waitrequest stuck high, TIMEOUT_CYC = 8.
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            if (pass_no == 0) begin
                @(negedge clk) t_reset_n = 1'b1;
            end else begin
                @(negedge clk) t_recheck = 1'b1;
                @(negedge clk) t_recheck = 1'b0;
                chk("to_rc_busy", 32'(t_busy), 1);
                chk("to_rc_err_clear", 32'(t_timeout_err), 0);
            end
            n = (pass_no == 1 && t_read) ? 1 : 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (t_read) n++;
                else if (n > 0) break;
            end
            chk("to_read_cycles", 32'(n), 32'd8);
            chk("to_address", 32'(t_address), 0);
            chk("to_err", 32'(t_timeout_err), 1);
            chk("to_id_ok", 32'(t_id_ok), 0);
            chk("to_ts_ok", 32'(t_ts_ok), 0);
            @(negedge clk);
            chk("to_done", 32'(t_done), 1);
            chk("to_pass", 32'(t_pass), 0);
            chk("to_busy", 32'(t_busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/limbus_sysid_check.md
# limbus_sysid_check

Avalon-MM master that sits directly upstream of the limbus system-ID slave and consumes its two read-only words: the ID at address 0 and the build timestamp at address 1. After reset, and on each `recheck` pulse, it reads both words, compares them with build-time expected values, and publishes pass/fail, per-word match flags, a bus-timeout flag and the captured values. Status logic and the boot sequencer use it to refuse operation when the FPGA image does not match the software build.

## Interface
- `EXP_ID`, 32'd0: expected word at address 0.
- `EXP_TIMESTAMP`, 32'd1415787354: expected word at address 1.
- `TIMEOUT_CYC`, 255: maximum cycles allowed per read transaction (request plus data wait). Legal range is 1..65535.

- `clock`  in  1: the only clock. All logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `recheck`  in  1: single-cycle pulse that starts a new check.
- `av_address`  out  1: word address. 0 selects the ID, 1 selects the timestamp.
- `av_read`  out  1: read request.
- `av_waitrequest`  in  1: slave stall.
- `av_readdatavalid`  in  1: read data valid.
- `av_readdata`  in  32: read data.
- `busy`  out  1: a check is in progress.
- `done`  out  1: at least one check has completed since reset.
- `pass`  out  1: the last check matched both words with no timeout.
- `id_ok`  out  1: the ID word matched.
- `ts_ok`  out  1: the timestamp word matched.
- `timeout_err`  out  1: the last check aborted on a timeout.
- `id_val`  out  32: captured ID word.
- `ts_val`  out  32: captured timestamp word.

## Operation
- The FSM has six states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE is entered only through reset. On the next clock it moves unconditionally to ID_REQ, so every reset produces one automatic check.
- **ID_REQ:** `av_read=1`, `av_address=0`. Both stay stable while `av_waitrequest=1`.
  - The request is accepted in a cycle with `av_read && !av_waitrequest`. If `av_readdatavalid` is also high in that cycle, the data is captured and the FSM goes to TS_REQ. Otherwise it goes to ID_WAIT.
- **ID_WAIT:** `av_read=0`. On `av_readdatavalid` it captures `id_val`, sets `id_ok = (av_readdata == EXP_ID)`, and goes to TS_REQ.
- **TS_REQ / TS_WAIT:** Same behaviour as ID_REQ / ID_WAIT, with `av_address=1`. The result goes to `ts_val` and `ts_ok`, and the FSM then goes to DONE.
- **DONE:** `av_read=0`.
  - `pass = id_ok & ts_ok & !timeout_err`; `done=1`.
  - `recheck` moves the FSM to ID_REQ and clears `id_ok`, `ts_ok`, `pass` and `timeout_err`.
  - `id_val` and `ts_val` keep their values until they are overwritten.
- **Timeout:**
  - A 16-bit counter clears on entry to each REQ state and increments every cycle spent in REQ or WAIT.
  - If the counter reaches `TIMEOUT_CYC - 1` without data being captured, the FSM goes to DONE with `timeout_err=1` and `pass=0`. `av_read` drops in that same transition.
  - The match flag for the aborted word stays 0.
- `av_readdatavalid` in any state other than ID_REQ, ID_WAIT, TS_REQ or TS_WAIT is ignored. This covers stale responses.
- `recheck` while `busy` is ignored; it is not queued.
- `busy` = 1 in IDLE, ID_REQ, ID_WAIT, TS_REQ and TS_WAIT.

## Timing
- **Reset values:** state IDLE, `av_read=0`, `av_address=0`, `busy=1`, `done=0`, `pass=0`, `id_ok=0`, `ts_ok=0`, `timeout_err=0`, `id_val=0`, `ts_val=0`, counter 0.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.
- **Zero-wait, zero-latency slave** (`av_readdatavalid` in the accept cycle):
  - reset release → ID_REQ after 1 cycle;
  - `av_read` is high for 1 cycle at address 0, then 1 cycle at address 1;
  - `done`/`pass` are valid 4 cycles after the first clock edge with `reset_n` high.
- **Latency-1 slave:** adds one WAIT cycle per word.
- **Mid-check reset:** `av_read` drops asynchronously and all outputs return to their reset values.
- **recheck in DONE:** `busy` rises the next cycle and `pass` clears in that same cycle.

## Test plan
- **Nominal boot:** zero-wait slave returns 0 at address 0 and 1415787354 at address 1 → `done=1`, `pass=1`, `id_ok=1`, `ts_ok=1`, `id_val=0`, `ts_val=1415787354`, total 4 cycles after reset release.
- **Timestamp mismatch:** slave returns 0x12345678 at address 1 → `pass=0`, `id_ok=1`, `ts_ok=0`, `ts_val=0x12345678`, `timeout_err=0`.
- **Wait states:** `av_waitrequest` is held high for 5 cycles on each request and `av_readdatavalid` comes 2 cycles after accept → address and read stay stable during the stall, one read per word, `pass=1`.
- **Timeout:** `TIMEOUT_CYC=8` with `av_waitrequest` stuck high → `av_read` drops after 8 cycles in ID_REQ, `timeout_err=1`, `pass=0`, `id_ok=0`, `done=1`.
- **recheck:**
  - A pulse during `busy` → ignored; exactly two reads occur.
  - A pulse in DONE, with the slave now returning ID 5 → a new check runs, `id_ok=0`, `pass=0`, `id_val=5`.
- **Reset mid-check:** `reset_n` is asserted low while in TS_WAIT → all outputs go to their reset values immediately, and after release a full check reruns from address 0.
